// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: FSM encoding,
// a constant-function log2 helper and the default 3x3 kernel size.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int K3_TAPS = 9;

  // Ceiling log2; clog2(1) = 0 so a single-tap window adds no guard bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered unsigned multiplier stage. Captures din0*din1 on accept and
// flags the product valid for exactly one cycle so a downstream
// accumulator can add it without further qualification.
module mac_mult_stage #(
  parameter int DW = 4,
  parameter int WW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [DW-1:0]    din0,
  input  logic [WW-1:0]    din1,
  output logic [DW+WW-1:0] prod_r,
  output logic             prod_v
);

  localparam int PW = DW + WW;

  // Product register: full-width result, valid pulse follows accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= '0;
      prod_v <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod_r <= PW'(din0) * PW'(din1);
      end
    end
  end

endmodule

// File: rtl/conv_mac_unit.sv
// Sequential multiply-accumulate for one convolution window of TAPS
// pixel/weight pairs. Pairs stream in through a valid/ready port, are
// multiplied in a registered stage and summed; the window result is
// presented through a valid/ready port, saturated or wrapped to OW bits.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int DW   = 4,
  parameter int WW   = 4,
  parameter int TAPS = K3_TAPS,
  parameter int OW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sat_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din0,
  input  logic [WW-1:0] din1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] dout,
  output logic          ovf,
  output logic          busy
);

  localparam int PW = DW + WW;
  localparam int AW = PW + clog2(TAPS);
  localparam int CW = (clog2(TAPS + 1) < 1) ? 1 : clog2(TAPS + 1);

  conv_state_t   state_reg;
  conv_state_t   state_next;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          sat_r;
  logic [PW-1:0] prod_r;
  logic          prod_v;
  logic          accept;
  logic          last_pair;
  logic          acc_ovf;
  logic [OW-1:0] acc_low;

  // A pair is consumed only while collecting; in_ready is high exactly then.
  assign accept    = in_valid && (state_reg == ACC);
  assign last_pair = (cnt == CW'(TAPS - 1));

  mac_mult_stage #(
    .DW(DW),
    .WW(WW)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .accept(accept),
    .din0  (din0),
    .din1  (din1),
    .prod_r(prod_r),
    .prod_v(prod_v)
  );

  // Anything above bit OW-1 means the window sum does not fit the output.
  generate
    if (AW > OW) begin : g_wide_acc
      assign acc_ovf = |acc[AW-1:OW];
      assign acc_low = acc[OW-1:0];
    end else begin : g_narrow_acc
      assign acc_ovf = 1'b0;
      assign acc_low = OW'(acc);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; DRAIN exists so the final product lands in acc.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (accept && last_pair) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Window bookkeeping: clear on a new window, count accepted pairs, sum products.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      sat_r <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        acc   <= '0;
        cnt   <= '0;
        sat_r <= sat_mode;
      end else begin
        if (prod_v) begin
          acc <= acc + AW'(prod_r);
        end
        if (accept) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Result is only driven while presenting; acc is frozen in DONE.
  always_comb begin
    dout = '0;
    ovf  = 1'b0;
    if (state_reg == DONE) begin
      ovf  = acc_ovf;
      dout = (sat_r && acc_ovf) ? {OW{1'b1}} : acc_low;
    end
  end

endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit: stimulus pushes expected window results
// into a queue, monitors pop and compare on each DUT result handshake.
module tb_conv_mac_unit;

  typedef struct {
    int dout;
    bit ovf;
    int lat;
    int start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sat_mode, in_valid, out_ready;
  logic [3:0] din0, din1;
  logic       in_ready, out_valid, ovf, busy;
  logic [7:0] dout;

  logic        c_start, c_sat_mode, c_in_valid, c_out_ready;
  logic [7:0]  c_din0, c_din1;
  logic        c_in_ready, c_out_valid, c_ovf, c_busy;
  logic [15:0] c_dout;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t c_q[$];
  bit   lat_done = 0;
  int   pix[9];
  int   wt[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_unit dut (
    .clk(clk), .rst(rst), .start(start), .sat_mode(sat_mode),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf), .busy(busy)
  );

  conv_mac_unit #(.DW(8), .WW(8), .TAPS(1), .OW(16)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .sat_mode(c_sat_mode),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .din0(c_din0), .din1(c_din1),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .dout(c_dout), .ovf(c_ovf), .busy(c_busy)
  );

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Inputs change 2 time units after the rising edge; monitors sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Main DUT monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result dout=%0d ovf=%0d want none", dout, ovf);
        end else begin
          if (int'(dout) != exp_q[0].dout || ovf != exp_q[0].ovf) begin
            errors++;
            $display("FAIL result dout=%0d ovf=%0d want dout=%0d ovf=%0d",
                     dout, ovf, exp_q[0].dout, exp_q[0].ovf);
          end
          if (!lat_done && exp_q[0].lat >= 0) begin
            checks++;
            if (cyc - exp_q[0].start_cyc != exp_q[0].lat) begin
              errors++;
              $display("FAIL latency got %0d want %0d", cyc - exp_q[0].start_cyc, exp_q[0].lat);
            end
          end
          lat_done = 1;
          if (out_ready) begin
            $display("result dout=%0d ovf=%0d accepted at cycle %0d", dout, ovf, cyc);
            void'(exp_q.pop_front());
            lat_done = 0;
          end
        end
      end else begin
        checks++;
        if (dout != 8'd0 || ovf != 1'b0) begin
          errors++;
          $display("FAIL idle_outputs dout=%0d ovf=%0d want 0 0", dout, ovf);
        end
      end
    end
  end

  // Corner-parameter DUT monitor (out_ready tied high).
  always @(negedge clk) begin
    if (!rst && c_out_valid) begin
      checks++;
      if (c_q.size() == 0) begin
        errors++;
        $display("FAIL corner_unexpected dout=%0d want none", c_dout);
      end else begin
        if (int'(c_dout) != c_q[0].dout || c_ovf != c_q[0].ovf) begin
          errors++;
          $display("FAIL corner_result dout=%0d ovf=%0d want dout=%0d ovf=%0d",
                   c_dout, c_ovf, c_q[0].dout, c_q[0].ovf);
        end
        checks++;
        if (cyc - c_q[0].start_cyc != c_q[0].lat) begin
          errors++;
          $display("FAIL corner_latency got %0d want %0d", cyc - c_q[0].start_cyc, c_q[0].lat);
        end
        $display("corner result dout=%0d ovf=%0d at cycle %0d", c_dout, c_ovf, cyc);
        void'(c_q.pop_front());
      end
    end
  end

  // Issue one window: n pairs from pix/wt, optional bubbles and spurious control.
  task automatic run_window(input int n, input bit sat, input bit gaps, input bit spur,
                            input int exp_d, input bit exp_o, input bit push);
    exp_t e;
    int   k;
    start    = 1'b1;
    sat_mode = sat;
    e.dout = exp_d;
    e.ovf = exp_o;
    e.lat = gaps ? -1 : 11;
    e.start_cyc = cyc;
    if (push) exp_q.push_back(e);
    tick();
    start    = 1'b0;
    sat_mode = ~sat;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      din0 = 4'(pix[i]);
      din1 = 4'(wt[i]);
      if (spur && i == 4) start = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
        tick();
        k++;
      end
      if (k == 50) chk("in_ready_timeout", 0, 1);
      tick();
      start = 1'b0;
    end
    if (spur) begin
      // Pairs offered in DRAIN, DONE and IDLE must not be consumed; start in DONE is ignored.
      in_valid = 1'b1;
      din0 = 4'd15;
      din1 = 4'd15;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    din0 = '0;
    din1 = '0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic finish_window();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) chk("window_timeout", 0, 1);
  endtask

  task automatic fill(input int p0, input int pstep, input int w);
    for (int i = 0; i < 9; i++) begin
      pix[i] = p0 + pstep * i;
      wt[i]  = w;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 0; sat_mode = 0; in_valid = 0; out_ready = 1; din0 = 0; din1 = 0;
    c_start = 0; c_sat_mode = 0; c_in_valid = 0; c_out_ready = 1; c_din0 = 0; c_din1 = 0;
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Identity kernel: 1..9 x 1 = 45.
    fill(1, 1, 1);
    run_window(9, 1, 0, 0, 45, 0, 1);
    finish_window();

    // Max operands: 9 x 225 = 2025, saturated then wrapped.
    fill(15, 0, 15);
    run_window(9, 1, 0, 0, 255, 1, 1);
    finish_window();
    run_window(9, 0, 0, 0, 233, 1, 1);
    finish_window();

    // Bubbles and back-pressure: 9 x 6 = 54 held while out_ready is low.
    fill(2, 0, 3);
    out_ready = 1'b0;
    run_window(9, 1, 1, 0, 54, 0, 1);
    wait_valid();
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_out_valid", out_valid, 0);
    chk("bp_queue_drained", exp_q.size(), 0);

    // Spurious control: in_valid in IDLE, start in ACC and DONE; 2*(1..9) = 90.
    in_valid = 1'b1; din0 = 4'd15; din1 = 4'd15;
    repeat (2) tick();
    chk("idle_in_valid_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    fill(1, 1, 2);
    run_window(9, 0, 0, 1, 90, 0, 1);
    repeat (3) tick();
    chk("spur_no_extra_busy", busy, 0);
    chk("spur_no_extra_valid", out_valid, 0);
    chk("spur_queue_drained", exp_q.size(), 0);

    // Reset after 4 of 9 pairs, then a clean 9 x (1,1) window.
    fill(5, 0, 5);
    run_window(4, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    tick();
    fill(1, 0, 1);
    run_window(9, 1, 0, 0, 9, 0, 1);
    finish_window();

    // Corner parameters: TAPS=1, 8x8 bits, OW=16: 255*255 = 65025.
    begin
      exp_t e;
      int   k;
      c_start = 1'b1;
      c_sat_mode = 1'b1;
      e.dout = 65025; e.ovf = 0; e.lat = 3; e.start_cyc = cyc;
      c_q.push_back(e);
      tick();
      c_start = 1'b0;
      chk("corner_in_ready", c_in_ready, 1);
      c_in_valid = 1'b1; c_din0 = 8'd255; c_din1 = 8'd255;
      tick();
      c_in_valid = 1'b0;
      k = 0;
      while ((c_q.size() != 0 || c_busy) && k < 50) begin
        tick();
        k++;
      end
      if (k == 50) chk("corner_timeout", 0, 1);
      chk("corner_idle_busy", c_busy, 0);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
